// File: rtl/sync_mux_pkg.sv
// Shared types and constants for the sync_mux_nto1 registered multiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sync_mux_pkg;

  // Width of the settle countdown; also bounds SETTLE_CYC to 0..255.
  localparam int SETTLE_W = 8;

  // RUN: output tracks the current channel. SETTLE: output frozen while a
  // switchover counts down.
  typedef enum logic {
    RUN    = 1'b0,
    SETTLE = 1'b1
  } state_e;

endpackage

// File: rtl/sync_mux_settle_cnt.sv
// Loadable down-counter that times the frozen window of a channel switchover.
// Latency: load/decrement visible one cycle after the edge; zero is combinational from the count.
// Backpressure: none; load has priority over dec and the count never wraps below zero.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        load load_val on the next edge
//   load_val    reload value
//   dec         decrement on the next edge (ignored at zero)
//   zero        count is currently zero
module sync_mux_settle_cnt
  import sync_mux_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [SETTLE_W-1:0] cnt_q;
  logic [SETTLE_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sync_mux_nto1.sv
// N-input W-bit registered mux with frozen-output switchover, hold and bad-select flag.
// Latency: din to dout 1 cycle; a channel change shows new data SETTLE_CYC+1 cycles after it is sampled.
// Backpressure: none; hold freezes dout, sel changes during a switchover retarget it.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   din         N packed channels, channel i at din[i*W +: W]
//   sel         requested channel
//   hold        freeze dout while high
//   dout        registered selected data
//   busy        switchover in progress
//   sel_chg     one-cycle pulse per accepted change or retarget
//   err         registered flag, sel >= N last cycle
//   chg_cnt     saturating count of completed switchovers (only with SYNC_MUX_CNT_EN)
//
// Build option: define SYNC_MUX_CNT_EN to add the chg_cnt port and its counter.
module sync_mux_nto1
  import sync_mux_pkg::*;
#(
  parameter int N          = 4,
  parameter int W          = 8,
  parameter int SETTLE_CYC = 2,
  parameter int SEL_W      = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   din,
  input  logic [SEL_W-1:0] sel,
  input  logic             hold,
  output logic [W-1:0]     dout,
  output logic             busy,
  output logic             sel_chg,
  output logic             err
`ifdef SYNC_MUX_CNT_EN
  ,
  output logic [15:0]      chg_cnt
`endif
);

  // One extra bit so N itself is representable when N is a power of two.
  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

  localparam logic [SETTLE_W-1:0] RELOAD =
    (SETTLE_CYC > 0) ? SETTLE_W'(SETTLE_CYC - 1) : '0;

  localparam bit IMMEDIATE = (SETTLE_CYC == 0);

  // Unpacked view of the channel bus for simple indexed selection.
  logic [W-1:0] ch [N];

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch[i] = din[i*W +: W];
  end

  state_e           state_q, state_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0] tgt_sel_q, tgt_sel_d;
  logic [W-1:0]     dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             sel_chg_q, sel_chg_d;
  logic             err_q, err_d;

  logic             sel_ok;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             done;

  assign sel_ok = ({1'b0, sel} < N_EXT);

  sync_mux_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (RELOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    tgt_sel_d = tgt_sel_q;
    dout_d    = dout_q;
    busy_d    = busy_q;
    sel_chg_d = 1'b0;
    err_d     = !sel_ok;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    done      = 1'b0;

    case (state_q)
      RUN: begin
        if (sel_ok && (sel != cur_sel_q)) begin
          sel_chg_d = 1'b1;
          if (IMMEDIATE) begin
            cur_sel_d = sel;
            done      = 1'b1;
            if (!hold) begin
              dout_d = ch[sel];
            end
          end else begin
            // dout is left untouched from this edge until the window closes.
            tgt_sel_d = sel;
            cnt_load  = 1'b1;
            busy_d    = 1'b1;
            state_d   = SETTLE;
          end
        end else if (!hold) begin
          // Invalid selects fall here too: keep tracking the current channel.
          dout_d = ch[cur_sel_q];
        end
      end

      SETTLE: begin
        // A return to cur_sel is just another new target; no early exit.
        if (sel_ok && (sel != tgt_sel_q)) begin
          tgt_sel_d = sel;
          cnt_load  = 1'b1;
          sel_chg_d = 1'b1;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          cur_sel_d = tgt_sel_q;
          busy_d    = 1'b0;
          state_d   = RUN;
          done      = 1'b1;
        end
      end

      default: begin
        state_d = RUN;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cur_sel_q <= '0;
      tgt_sel_q <= '0;
      dout_q    <= '0;
      busy_q    <= 1'b0;
      sel_chg_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      tgt_sel_q <= tgt_sel_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      sel_chg_q <= sel_chg_d;
      err_q     <= err_d;
    end
  end

  assign dout    = dout_q;
  assign busy    = busy_q;
  assign sel_chg = sel_chg_q;
  assign err     = err_q;

`ifdef SYNC_MUX_CNT_EN
  logic [15:0] chg_cnt_q, chg_cnt_d;

  always_comb begin
    chg_cnt_d = chg_cnt_q;
    if (done && (chg_cnt_q != 16'hFFFF)) begin
      chg_cnt_d = chg_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_cnt_q <= '0;
    end else begin
      chg_cnt_q <= chg_cnt_d;
    end
  end

  assign chg_cnt = chg_cnt_q;
`else
  logic unused_done;
  assign unused_done = done;
`endif

endmodule
